usb_cmd_bridge: RTL and testbench

USB_CMD_BRIDGE -- requirements
Module: usb_cmd_bridge

---
 rtl/usb_cmd_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_usb_cmd_bridge.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_bridge.sv
// FX2 command-packet bridge: parses 16-bit OUT-endpoint words into picorv32-style
// memory accesses and streams a header/data/status response on the IN path.
module usb_cmd_bridge #(
  parameter int unsigned ADDR_INC = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [3:0] {
    IDLE, LEN, ALO, AHI, WLO, WHI, MWR, MRD, RLO, RHI, DRAIN, RSP_HDR, RSP_STAT
  } state_t;

  localparam logic [31:0] INC = 32'(ADDR_INC);

  state_t      r_state;
  logic [7:0]  r_op;
  logic [15:0] r_cnt;
  logic [31:0] r_addr;
  logic [15:0] r_status;
  logic [31:0] r_wdata;
  logic [15:0] r_rhi;
  logic        r_half;
  logic [15:0] r_tx_data;
  logic        r_tx_valid;
  logic        r_tx_last;
  logic        r_mem_valid;
  logic [3:0]  r_mem_wstrb;

  logic        w_rx_state;
  logic        w_rx_fire;
  logic        w_tx_fire;
  logic        w_op_ok;
  logic [15:0] w_status;
  logic [15:0] w_hdr;

  always_comb begin
    w_rx_state = 1'b0;
    case (r_state)
      IDLE, LEN, ALO, AHI, WLO, WHI, DRAIN: w_rx_state = 1'b1;
      default:                             w_rx_state = 1'b0;
    endcase
  end

  // Gated by reset_n so the port reads 0 while reset is held.
  assign rx_ready  = reset_n & w_rx_state;
  assign w_rx_fire = rx_valid & rx_ready;
  assign w_tx_fire = r_tx_valid & tx_ready;
  assign w_op_ok   = (r_op == 8'h01) || (r_op == 8'h02);
  assign w_hdr     = w_op_ok ? {8'h5A, r_op} : 16'h5AFF;

  // r_cnt still holds LEN and r_addr[1:0] comes from ADDR_LO while in AHI.
  always_comb begin
    w_status = 16'h0000;
    if (!w_op_ok)                  w_status = 16'h0001;
    else if (r_cnt == 16'd0)       w_status = 16'h0003;
    else if (r_addr[1:0] != 2'b00) w_status = 16'h0002;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_status    <= '0;
      r_wdata     <= '0;
      r_rhi       <= '0;
      r_half      <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_last   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_wstrb <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_rx_fire && rx_data[15:8] == 8'hA5) begin
          r_op    <= rx_data[7:0];
          r_state <= LEN;
        end
        LEN: if (w_rx_fire) begin
          r_cnt   <= rx_data;
          r_state <= ALO;
        end
        ALO: if (w_rx_fire) begin
          r_addr[15:0] <= rx_data;
          r_state      <= AHI;
        end
        AHI: if (w_rx_fire) begin
          r_addr[31:16] <= rx_data;
          r_status      <= w_status;
          r_half        <= 1'b0;
          if (w_status == 16'h0000 && r_op == 8'h01) begin
            r_state <= WLO;
          end else if (r_op == 8'h01 && r_cnt != 16'd0) begin
            r_state <= DRAIN;
          end else begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_hdr;
            r_state    <= RSP_HDR;
          end
        end
        WLO: if (w_rx_fire) begin
          r_wdata[15:0] <= rx_data;
          r_state       <= WHI;
        end
        WHI: if (w_rx_fire) begin
          r_wdata[31:16] <= rx_data;
          r_mem_valid    <= 1'b1;
          r_mem_wstrb    <= 4'hF;
          r_state        <= MWR;
        end
        MWR: if (mem_ready) begin
          r_mem_valid <= 1'b0;
          r_mem_wstrb <= 4'h0;
          r_addr      <= r_addr + INC;
          r_cnt       <= r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_hdr;
            r_state    <= RSP_HDR;
          end else begin
            r_state <= WLO;
          end
        end
        DRAIN: if (w_rx_fire) begin
          r_half <= ~r_half;
          if (r_half) begin
            r_cnt <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= w_hdr;
              r_state    <= RSP_HDR;
            end
          end
        end
        RSP_HDR: if (w_tx_fire) begin
          if (r_status == 16'h0000 && r_op == 8'h02) begin
            r_tx_valid  <= 1'b0;
            r_mem_valid <= 1'b1;
            r_mem_wstrb <= 4'h0;
            r_state     <= MRD;
          end else begin
            r_tx_data <= r_status;
            r_tx_last <= 1'b1;
            r_state   <= RSP_STAT;
          end
        end
        MRD: if (mem_ready) begin
          r_mem_valid <= 1'b0;
          r_rhi       <= mem_rdata[31:16];
          r_tx_data   <= mem_rdata[15:0];
          r_tx_valid  <= 1'b1;
          r_addr      <= r_addr + INC;
          r_state     <= RLO;
        end
        RLO: if (w_tx_fire) begin
          r_tx_data <= r_rhi;
          r_state   <= RHI;
        end
        RHI: if (w_tx_fire) begin
          r_cnt <= r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            r_tx_data <= r_status;
            r_tx_last <= 1'b1;
            r_state   <= RSP_STAT;
          end else begin
            r_tx_valid  <= 1'b0;
            r_mem_valid <= 1'b1;
            r_state     <= MRD;
          end
        end
        RSP_STAT: if (w_tx_fire) begin
          r_tx_valid <= 1'b0;
          r_tx_last  <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign tx_last   = r_tx_last;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_usb_cmd_bridge.sv
// Directed bench for usb_cmd_bridge: background sink/memory responders log traffic,
// scenario tasks compare logged traffic against hand-computed vectors.
module tb_usb_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] rx_data = 16'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  usb_cmd_bridge #(.ADDR_INC(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;
  int rx_tmo = 0;
  bit tx_toggle = 1'b0;
  int mem_lat = 0;
  logic [16:0] txq[$];   // {last, data}
  logic [67:0] memq[$];  // {addr, wdata, wstrb}

  function automatic logic [31:0] rdfn(input logic [31:0] a);
    return (a == 32'h20) ? 32'hDEADBEEF : (a ^ 32'hA5A50000);
  endfunction

  task automatic tx_server();
    logic stall = 1'b0;
    logic [16:0] held = '0;
    forever begin
      @(negedge clk);
      if (stall && reset_n) begin
        n_vec++;
        if (tx_valid !== 1'b1 || {tx_last, tx_data} !== held) begin
          n_err++;
          $display("FAIL tx_hold: got valid=%b word=%h, need valid=1 word=%h", tx_valid, {tx_last, tx_data}, held);
        end
      end
      tx_ready = tx_toggle ? ~tx_ready : 1'b1;
      if (reset_n && tx_valid === 1'b1 && tx_ready) txq.push_back({tx_last, tx_data});
      stall = reset_n && (tx_valid === 1'b1) && !tx_ready;
      held  = {tx_last, tx_data};
    end
  endtask

  task automatic mem_server();
    int w = 0;
    logic pend = 1'b0, done = 1'b0;
    logic [67:0] held = '0;
    forever begin
      @(negedge clk);
      if (reset_n && pend) begin
        n_vec++;
        if (mem_valid !== 1'b1 || {mem_addr, mem_wdata, mem_wstrb} !== held) begin
          n_err++;
          $display("FAIL mem_hold: got valid=%b req=%h, need valid=1 req=%h", mem_valid, {mem_addr, mem_wdata, mem_wstrb}, held);
        end
      end
      if (reset_n && done) begin
        n_vec++;
        if (mem_valid !== 1'b0) begin
          n_err++;
          $display("FAIL mem_drop: got mem_valid=%b, need 0", mem_valid);
        end
      end
      mem_ready = 1'b0;
      done = 1'b0;
      if (reset_n && mem_valid === 1'b1) begin
        mem_rdata = rdfn(mem_addr);
        if (w >= mem_lat) begin
          mem_ready = 1'b1;
          memq.push_back({mem_addr, mem_wdata, mem_wstrb});
          w = 0;
          done = 1'b1;
        end else w++;
      end
      pend = reset_n && (mem_valid === 1'b1) && !mem_ready;
      held = {mem_addr, mem_wdata, mem_wstrb};
    end
  endtask

  task automatic send_word(input logic [15:0] d);
    int c = 0;
    rx_data = d;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && c < 500) begin @(negedge clk); c++; end
    if (rx_ready !== 1'b1) rx_tmo++;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int c = 0;
    while (txq.size() < n && c < 3000) begin @(negedge clk); c++; end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({rx_ready, tx_valid, tx_last, mem_valid, mem_wstrb} !== 8'h0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b, need 0", {rx_ready, tx_valid, tx_last, mem_valid, mem_wstrb});
    end
    n_vec++;
    if ({tx_data, mem_addr, mem_wdata} !== 80'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h, need 0", {tx_data, mem_addr, mem_wdata});
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_ready: got %b, need 1", rx_ready);
    end
  endtask

  task automatic test_write();
    logic [15:0] w[8] = '{16'hA501, 16'h0002, 16'h0010, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [16:0] et[2] = '{17'h05A01, 17'h10000};
    logic [67:0] em[2] = '{{32'h10, 32'h22221111, 4'hF}, {32'h14, 32'h44443333, 4'hF}};
    logic [16:0] gt;
    logic [67:0] gm;
    txq.delete(); memq.delete(); rx_tmo = 0;
    foreach (w[i]) send_word(w[i]);
    wait_tx(2);
    n_vec++;
    if (rx_tmo !== 0 || txq.size() !== 2 || memq.size() !== 2) begin
      n_err++;
      $display("FAIL write_counts: got tmo=%0d tx=%0d mem=%0d, need 0/2/2", rx_tmo, txq.size(), memq.size());
    end
    for (int i = 0; i < 2; i++) begin
      gt = (i < txq.size()) ? txq[i] : 'x;
      gm = (i < memq.size()) ? memq[i] : 'x;
      n_vec++;
      if (gt !== et[i]) begin n_err++; $display("FAIL write_tx[%0d]: got %h, need %h", i, gt, et[i]); end
      n_vec++;
      if (gm !== em[i]) begin n_err++; $display("FAIL write_mem[%0d]: got %h, need %h", i, gm, em[i]); end
    end
  endtask

  task automatic test_read();
    logic [15:0] w[4] = '{16'hA502, 16'h0001, 16'h0020, 16'h0000};
    logic [16:0] et[4] = '{17'h05A02, 17'h0BEEF, 17'h0DEAD, 17'h10000};
    logic [16:0] gt;
    txq.delete(); memq.delete(); rx_tmo = 0;
    foreach (w[i]) send_word(w[i]);
    wait_tx(4);
    n_vec++;
    if (rx_tmo !== 0 || txq.size() !== 4 || memq.size() !== 1) begin
      n_err++;
      $display("FAIL read_counts: got tmo=%0d tx=%0d mem=%0d, need 0/4/1", rx_tmo, txq.size(), memq.size());
    end
    for (int i = 0; i < 4; i++) begin
      gt = (i < txq.size()) ? txq[i] : 'x;
      n_vec++;
      if (gt !== et[i]) begin n_err++; $display("FAIL read_tx[%0d]: got %h, need %h", i, gt, et[i]); end
    end
    n_vec++;
    if (memq.size() < 1 || {memq[0][67:36], memq[0][3:0]} !== {32'h20, 4'h0}) begin
      n_err++;
      $display("FAIL read_mem: got %h, need addr 00000020 wstrb 0", (memq.size() > 0) ? memq[0] : 68'h0);
    end
  endtask

  task automatic test_errors();
    logic [15:0] wb[4] = '{16'hA507, 16'h0001, 16'h0000, 16'h0000};
    logic [15:0] wm[6] = '{16'hA501, 16'h0001, 16'h0002, 16'h0000, 16'hAAAA, 16'hBBBB};
    logic [15:0] wz[4] = '{16'hA501, 16'h0000, 16'h0010, 16'h0000};
    logic [16:0] et[6] = '{17'h05AFF, 17'h10001, 17'h05A01, 17'h10002, 17'h05A01, 17'h10003};
    logic [16:0] gt;
    txq.delete(); memq.delete(); rx_tmo = 0;
    foreach (wb[i]) send_word(wb[i]);
    wait_tx(2);
    foreach (wm[i]) send_word(wm[i]);
    wait_tx(4);
    foreach (wz[i]) send_word(wz[i]);
    wait_tx(6);
    n_vec++;
    if (rx_tmo !== 0 || txq.size() !== 6 || memq.size() !== 0) begin
      n_err++;
      $display("FAIL err_counts: got tmo=%0d tx=%0d mem=%0d, need 0/6/0", rx_tmo, txq.size(), memq.size());
    end
    for (int i = 0; i < 6; i++) begin
      gt = (i < txq.size()) ? txq[i] : 'x;
      n_vec++;
      if (gt !== et[i]) begin n_err++; $display("FAIL err_tx[%0d]: got %h, need %h", i, gt, et[i]); end
    end
  endtask

  task automatic test_stall_wrap();
    logic [15:0] w[5] = '{16'h1234, 16'hA502, 16'h0002, 16'hFFFC, 16'hFFFF};
    logic [16:0] et[6] = '{17'h05A02, 17'h0FFFC, 17'h05A5A, 17'h00000, 17'h0A5A5, 17'h10000};
    logic [31:0] ea[2] = '{32'hFFFFFFFC, 32'h00000000};
    logic [16:0] gt;
    txq.delete(); memq.delete(); rx_tmo = 0;
    tx_toggle = 1'b1; mem_lat = 3;
    foreach (w[i]) send_word(w[i]);
    wait_tx(6);
    tx_toggle = 1'b0; mem_lat = 0;
    n_vec++;
    if (rx_tmo !== 0 || txq.size() !== 6 || memq.size() !== 2) begin
      n_err++;
      $display("FAIL wrap_counts: got tmo=%0d tx=%0d mem=%0d, need 0/6/2", rx_tmo, txq.size(), memq.size());
    end
    for (int i = 0; i < 6; i++) begin
      gt = (i < txq.size()) ? txq[i] : 'x;
      n_vec++;
      if (gt !== et[i]) begin n_err++; $display("FAIL wrap_tx[%0d]: got %h, need %h", i, gt, et[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (i >= memq.size() || {memq[i][67:36], memq[i][3:0]} !== {ea[i], 4'h0}) begin
        n_err++;
        $display("FAIL wrap_mem[%0d]: got %h, need addr %h wstrb 0", i, (i < memq.size()) ? memq[i] : 68'h0, ea[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[8] = '{16'hA502, 16'h0001, 16'h0020, 16'h0000, 16'hA507, 16'h0000, 16'h0002, 16'h0000};
    logic [16:0] et[6] = '{17'h05A02, 17'h0BEEF, 17'h0DEAD, 17'h10000, 17'h05AFF, 17'h10001};
    logic [16:0] gt;
    txq.delete(); memq.delete(); rx_tmo = 0;
    foreach (w[i]) send_word(w[i]);
    wait_tx(6);
    n_vec++;
    if (rx_tmo !== 0 || txq.size() !== 6 || memq.size() !== 1) begin
      n_err++;
      $display("FAIL b2b_counts: got tmo=%0d tx=%0d mem=%0d, need 0/6/1", rx_tmo, txq.size(), memq.size());
    end
    for (int i = 0; i < 6; i++) begin
      gt = (i < txq.size()) ? txq[i] : 'x;
      n_vec++;
      if (gt !== et[i]) begin n_err++; $display("FAIL b2b_tx[%0d]: got %h, need %h", i, gt, et[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ww[5] = '{16'hA501, 16'h0001, 16'h0040, 16'h0000, 16'hAAAA};
    logic [15:0] wr[4] = '{16'hA502, 16'h0001, 16'h0020, 16'h0000};
    logic [16:0] et[4] = '{17'h05A02, 17'h0BEEF, 17'h0DEAD, 17'h10000};
    logic [16:0] gt;
    txq.delete(); memq.delete(); rx_tmo = 0;
    foreach (ww[i]) send_word(ww[i]);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({rx_ready, tx_valid, tx_last, mem_valid, mem_wstrb, tx_data, mem_addr, mem_wdata} !== 88'h0) begin
      n_err++;
      $display("FAIL midreset_outs: got %h, need 0", {rx_ready, tx_valid, tx_last, mem_valid, mem_wstrb, tx_data, mem_addr, mem_wdata});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    foreach (wr[i]) send_word(wr[i]);
    wait_tx(4);
    n_vec++;
    if (rx_tmo !== 0 || txq.size() !== 4 || memq.size() !== 1) begin
      n_err++;
      $display("FAIL midreset_counts: got tmo=%0d tx=%0d mem=%0d, need 0/4/1", rx_tmo, txq.size(), memq.size());
    end
    for (int i = 0; i < 4; i++) begin
      gt = (i < txq.size()) ? txq[i] : 'x;
      n_vec++;
      if (gt !== et[i]) begin n_err++; $display("FAIL midreset_tx[%0d]: got %h, need %h", i, gt, et[i]); end
    end
    n_vec++;
    if (memq.size() < 1 || {memq[0][67:36], memq[0][3:0]} !== {32'h20, 4'h0}) begin
      n_err++;
      $display("FAIL midreset_mem: got %h, need addr 00000020 wstrb 0", (memq.size() > 0) ? memq[0] : 68'h0);
    end
  endtask

  initial begin
    fork
      tx_server();
      mem_server();
    join_none
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_stall_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule
